inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_req  output  1  fetch request to instruction memory.
REQ-006 mem_addr  output  32  word-aligned fetch address; bits[1:0] always 0.
REQ-007 mem_gnt  input  1  memory accepts request in the cycle mem_req&&mem_gnt.
REQ-008 mem_rvalid  input  1  read data valid; responses in order, one per granted request.
REQ-009 mem_rdata  input  32  instruction word.
REQ-010 redirect  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch address; bits[1:0] ignored (treated as 0).
REQ-012 inst_valid  output  1  buffer head holds an instruction.
REQ-013 inst  output  32  head instruction; 32'h0000_0013 (NOP) when inst_valid=0.
REQ-014 inst_pc  output  32  address of head instruction; 0 when inst_valid=0.
REQ-015 inst_ready  input  1  decoder consumes head when inst_valid&&inst_ready.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-017 IDLE->REQ when count<DEPTH (count = buffered entries, slot reserved for the outstanding fetch); otherwise stay IDLE.
REQ-018 In REQ: mem_req=1, mem_addr=fetch_pc, both held stable until mem_gnt; on grant go WAIT, fetch_pc+=4 (wraps modulo 2^32).
REQ-019 In WAIT: on mem_rvalid push {mem_rdata, granted pc}; next state REQ if count after push/pop <DEPTH, else IDLE.
REQ-020 Latency: mem_rvalid in cycle N -> inst_valid=1 in cycle N+1 when buffer was empty; no combinational bypass.
REQ-021 Buffer full: no request issued; push with simultaneous pop at full never overflows because issue is gated by REQ-017.
REQ-022 Push and pop in same cycle: count unchanged, order preserved.
REQ-023 Pop while empty: ignored, no state change.
REQ-024 redirect (any state): buffer flushed next cycle (inst_valid=0), fetch_pc=redirect_pc&~3; redirect has priority over push, pop and grant in that cycle.
REQ-025 redirect in IDLE or in REQ without grant: next state REQ (mem_addr changes to new pc, request may be re-presented immediately).
REQ-026 redirect in WAIT without mem_rvalid, or in REQ with mem_gnt same cycle: next state DROP.
REQ-027 redirect in WAIT with mem_rvalid same cycle: response discarded, next state REQ.
REQ-028 DROP: mem_req=0; discard next mem_rvalid, then REQ; further redirect in DROP only updates fetch_pc.
REQ-029 mem_rvalid in IDLE or REQ is a protocol error: ignored.

Reset
REQ-030 On rst: state IDLE, fetch_pc=RESET_PC, buffer empty, mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=NOP, inst_pc=0.
REQ-031 rst mid-operation: outstanding response abandoned; memory side is reset by the same rst, so no DROP needed.
REQ-032 First request asserted in the cycle after rst deasserts.

Structure
REQ-033 Package fetch_pkg: FSM state enum, NOP_INST constant, default DEPTH and RESET_PC.
REQ-034 Sub-module fetch_fifo: synchronous DEPTH x 64-bit FIFO (inst+pc) with flush, push, pop, count, full, empty.
REQ-035 inst_fetch contains FSM, fetch_pc register and credit gating only.

Verification
REQ-036 Reset, memory grants immediately and responds 1 cycle later with rdata=addr^32'hA5A5_0000, inst_ready=1 -> inst_pc sequence 0,4,8,12 with matching inst.
REQ-037 inst_ready=0, DEPTH=4 -> exactly 4 grants then mem_req stays 0; raising inst_ready for 1 cycle -> one new request.
REQ-038 Redirect to 32'h0000_0102 in WAIT, response 3 cycles later -> response dropped, next mem_addr=32'h0000_0100, inst_valid=0 until its data returns.
REQ-039 Redirect same cycle as mem_rvalid and inst_ready with full buffer -> buffer empty next cycle, no stale instruction ever presented.
REQ-040 fetch_pc 32'hFFFF_FFFC granted -> next mem_addr 32'h0000_0000, inst_pc reports FFFF_FFFC then 0.
REQ-041 rst asserted while in WAIT with 2 entries buffered -> next cycle all outputs at reset values, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : buffered instruction word plus the address it came from
//   NOP_INST      : word presented to decode when nothing is buffered
//   word_align    : clears the byte-offset bits of an address
package fetch_pkg;

    localparam int unsigned DEFAULT_DEPTH    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] FETCH_STRIDE     = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory request/response bus.
//   master : fetch unit side (drives mem_req/mem_addr)
//   slave  : memory side (drives mem_gnt/mem_rvalid/mem_rdata)
interface inst_fetch_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction buffer holding {inst, pc} pairs.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the buffer; wins over push and pop
//   push/data  : write one entry (accepted when not full, or when popping)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (undefined when empty)
//   count      : number of stored entries
//   full/empty : occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  fetch_entry_t            push_data,
    input  logic                    pop,
    output fetch_entry_t            head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   storage [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == CW'(0));
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = storage[rd_ptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one word fetch at a time, buffers returned
// instructions and presents them in order to decode.
//   clk, rst     : clock, synchronous active-high reset
//   mem          : instruction memory bus (master side)
//   redirect     : flush buffer and restart fetch at redirect_pc
//   redirect_pc  : new fetch address (byte offset ignored)
//   inst_valid   : head of buffer holds an instruction
//   inst/inst_pc : head instruction and its address (NOP/0 when empty)
//   inst_ready   : decode consumes the head this cycle
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_if.master       mem,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    input  logic               inst_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t   state;
    logic [31:0]    fetch_pc;
    logic [31:0]    req_pc;
    logic [31:0]    new_pc;

    fetch_entry_t   fifo_head;
    fetch_entry_t   fifo_in;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;
    logic [CW-1:0]  count_after;

    assign new_pc      = word_align(redirect_pc);
    assign inst_valid  = !fifo_empty;
    assign inst        = inst_valid ? fifo_head.inst : NOP_INST;
    assign inst_pc     = inst_valid ? fifo_head.pc   : 32'h0000_0000;

    // Redirect beats both push and pop; the FIFO flush handles the rest.
    assign fifo_pop    = inst_valid && inst_ready && !redirect;
    assign fifo_push   = (state == WAIT) && mem.mem_rvalid && !redirect;
    assign fifo_in     = '{inst: mem.mem_rdata, pc: req_pc};
    // Occupancy once this cycle's response lands; decides whether to refetch.
    assign count_after = fifo_count + CW'(1) - CW'(fifo_pop);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Fetch FSM with registered request outputs. A new request is only
    // issued when a buffer slot is free for its response, so the single
    // outstanding fetch always has somewhere to land.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            req_pc       <= RESET_PC;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= new_pc;
            case (state)
                IDLE: begin
                    state        <= REQ;
                    mem.mem_req  <= 1'b1;
                    mem.mem_addr <= new_pc;
                end
                REQ: begin
                    if (mem.mem_gnt) begin
                        // Already accepted: its response must be swallowed.
                        state       <= DROP;
                        mem.mem_req <= 1'b0;
                    end else begin
                        state        <= REQ;
                        mem.mem_addr <= new_pc;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        state        <= REQ;
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= new_pc;
                    end else begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (mem.mem_rvalid) begin
                        state        <= REQ;
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= new_pc;
                    end
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_full) begin
                        state        <= REQ;
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (mem.mem_gnt) begin
                        state       <= WAIT;
                        mem.mem_req <= 1'b0;
                        req_pc      <= fetch_pc;
                        fetch_pc    <= fetch_pc + FETCH_STRIDE;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        if (count_after < CW'(DEPTH)) begin
                            state        <= REQ;
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= fetch_pc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (mem.mem_rvalid) begin
                        state        <= REQ;
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= fetch_pc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a memory model with configurable
// grant/latency, a reference model of the buffer contents and fetch address,
// and directed plus random scenarios.
module tb_inst_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    inst_fetch_if mem_bus ();

    inst_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (mem_bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          epoch  = 0;
    int          grants = 0;
    int          drops  = 0;
    int          lat    = 1;
    logic        gnt_en = 1'b0;
    logic        rand_gnt = 1'b0;
    logic        redir_on_rv = 1'b0;
    logic        redir_fired = 1'b0;
    logic        hold_req = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [31:0] model_pc = RESET_PC;
    pend_t       pend_q[$];
    exp_t        exp_q[$];
    logic [31:0] grant_log[$];
    logic [31:0] cons_log[$];

    // One clock cycle: check settled outputs, drive memory, update the model.
    task automatic step();
        logic  rv;
        logic  gnt;
        pend_t p;
        exp_t  e;

        checks++;
        if (inst_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL inst_valid cyc %0d: got %b expected %b", cyc, inst_valid, exp_q.size() != 0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            if (inst !== e.inst || inst_pc !== e.pc) begin
                errors++;
                $display("FAIL head cyc %0d: got inst %h pc %h expected inst %h pc %h", cyc, inst, inst_pc, e.inst, e.pc);
            end
        end else if (inst !== NOP_INST || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL empty_head cyc %0d: got inst %h pc %h expected %h / 0", cyc, inst, inst_pc, NOP_INST);
        end
        checks++;
        if (mem_bus.mem_addr[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL addr_align cyc %0d: got %h", cyc, mem_bus.mem_addr);
        end
        if (hold_req) begin
            checks++;
            if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== hold_addr) begin
                errors++;
                $display("FAIL req_hold cyc %0d: got req %b addr %h expected 1 %h", cyc, mem_bus.mem_req, mem_bus.mem_addr, hold_addr);
            end
        end
        if (mem_bus.mem_req === 1'b1) begin
            checks++;
            if (pend_q.size() != 0 || exp_q.size() >= DEPTH) begin
                errors++;
                $display("FAIL credit cyc %0d: got req with %0d pending %0d buffered", cyc, pend_q.size(), exp_q.size());
            end
        end

        rv = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
        if (rand_gnt) gnt = ($urandom_range(0, 3) != 0);
        else          gnt = gnt_en;
        if (redir_on_rv && rv) begin
            redirect    = 1'b1;
            inst_ready  = 1'b1;
            redir_fired = 1'b1;
            redir_on_rv = 1'b0;
        end
        mem_bus.mem_gnt    = gnt;
        mem_bus.mem_rvalid = rv;
        mem_bus.mem_rdata  = rv ? (pend_q[0].addr ^ XOR_KEY) : 32'hDEAD_BEEF;

        if (rst) begin
            exp_q.delete();
            pend_q.delete();
            epoch++;
            model_pc = RESET_PC;
        end else begin
            if (inst_valid && inst_ready && !redirect) begin
                cons_log.push_back(inst_pc);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (rv) begin
                p = pend_q.pop_front();
                if (p.epoch == epoch && !redirect) begin
                    e.inst = p.addr ^ XOR_KEY;
                    e.pc   = p.addr;
                    exp_q.push_back(e);
                end else begin
                    drops++;
                end
            end
            if (mem_bus.mem_req && gnt) begin
                checks++;
                if (mem_bus.mem_addr !== model_pc) begin
                    errors++;
                    $display("FAIL grant_addr cyc %0d: got %h expected %h", cyc, mem_bus.mem_addr, model_pc);
                end
                grants++;
                grant_log.push_back(mem_bus.mem_addr);
                p.addr  = model_pc;
                p.epoch = epoch;
                p.due   = cyc + lat;
                pend_q.push_back(p);
                model_pc = model_pc + 32'd4;
            end
            if (redirect) begin
                exp_q.delete();
                epoch++;
                model_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
        hold_req  = mem_bus.mem_req && !gnt && !redirect && !rst;
        hold_addr = mem_bus.mem_addr;

        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (redir_fired) begin
            redirect    = 1'b0;
            inst_ready  = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        inst_ready  = 1'b0;
        rand_gnt    = 1'b0;
        redir_on_rv = 1'b0;
        redir_fired = 1'b0;
        step();
        step();
        rst = 1'b0;
        grants = 0;
        drops  = 0;
        grant_log.delete();
        cons_log.delete();
    endtask

    task automatic test_reset();
        gnt_en = 1'b0;
        rst    = 1'b1;
        step();
        step();
        checks++;
        if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_addr !== RESET_PC || inst_valid !== 1'b0 ||
            inst !== NOP_INST || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got req %b addr %h valid %b inst %h pc %h", mem_bus.mem_req,
                     mem_bus.mem_addr, inst_valid, inst, inst_pc);
        end
        rst = 1'b0;
        step();
        checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req: got req %b addr %h expected 1 %h", mem_bus.mem_req, mem_bus.mem_addr, RESET_PC);
        end
        step();
    endtask

    task automatic test_stream();
        int n;
        do_reset();
        gnt_en = 1'b1;
        lat = 1;
        inst_ready = 1'b1;
        n = 0;
        while (cons_log.size() < 4 && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (cons_log.size() < 4) begin
            errors++;
            $display("FAIL stream_timeout: got %0d instructions expected 4", cons_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cons_log[i] !== RESET_PC + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL stream_pc%0d: got %h expected %h", i, cons_log[i], RESET_PC + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        gnt_en = 1'b1;
        lat = 1;
        inst_ready = 1'b0;
        repeat (40) step();
        checks++;
        if (grants != DEPTH || mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_stall: got grants %0d req %b expected %0d 0", grants, mem_bus.mem_req, DEPTH);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        repeat (30) step();
        checks++;
        if (grants != DEPTH + 1 || mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL one_credit: got grants %0d req %b expected %0d 0", grants, mem_bus.mem_req, DEPTH + 1);
        end
    endtask

    task automatic test_redirect_wait();
        int n;
        int drops0;
        do_reset();
        gnt_en = 1'b1;
        lat = 3;
        inst_ready = 1'b1;
        n = 0;
        while (grants < 1 && n < 10) begin
            step();
            n++;
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        drops0 = drops;
        cons_log.delete();
        checks++;
        if (mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_req: got %b expected 0", mem_bus.mem_req);
        end
        n = 0;
        while (mem_bus.mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (mem_bus.mem_addr !== 32'h0000_0100 || drops != drops0 + 1) begin
            errors++;
            $display("FAIL redirect_addr: got addr %h drops %0d expected 00000100 %0d", mem_bus.mem_addr, drops, drops0 + 1);
        end
        n = 0;
        while (cons_log.size() < 1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (cons_log.size() < 1 || cons_log[0] !== 32'h0000_0100) begin
            errors++;
            $display("FAIL redirect_inst: got %0d entries expected pc 00000100", cons_log.size());
        end
    endtask

    task automatic test_redirect_full();
        int n;
        do_reset();
        gnt_en = 1'b1;
        lat = 2;
        inst_ready = 1'b0;
        n = 0;
        while (!(exp_q.size() == DEPTH - 1 && pend_q.size() == 1) && n < 40) begin
            step();
            n++;
        end
        redirect_pc = 32'h0000_0200;
        redir_on_rv = 1'b1;
        n = 0;
        while (!redir_fired && n < 10) begin
            step();
            n++;
        end
        redir_fired = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL flush_full: got valid %b req %b addr %h expected 0 1 00000200", inst_valid,
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        inst_ready = 1'b1;
        cons_log.delete();
        n = 0;
        while (cons_log.size() < 1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (cons_log.size() < 1 || cons_log[0] !== 32'h0000_0200) begin
            errors++;
            $display("FAIL flush_next: got %0d entries expected pc 00000200", cons_log.size());
        end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        gnt_en = 1'b1;
        lat = 1;
        inst_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFD;
        step();
        redirect = 1'b0;
        grant_log.delete();
        cons_log.delete();
        n = 0;
        while (cons_log.size() < 2 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (grant_log.size() < 2 || grant_log[0] !== 32'hFFFF_FFFC || grant_log[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got %0d grants expected FFFFFFFC then 0", grant_log.size());
        end
        checks++;
        if (cons_log.size() < 2 || cons_log[0] !== 32'hFFFF_FFFC || cons_log[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: got %0d instructions expected FFFFFFFC then 0", cons_log.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        gnt_en = 1'b1;
        lat = 3;
        inst_ready = 1'b0;
        n = 0;
        while (!(exp_q.size() == 2 && pend_q.size() == 1) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 2) begin
            errors++;
            $display("FAIL mid_setup: got %0d buffered expected 2", exp_q.size());
        end
        rst = 1'b1;
        step();
        checks++;
        if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_addr !== RESET_PC || inst_valid !== 1'b0 ||
            inst !== NOP_INST || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got req %b addr %h valid %b inst %h pc %h", mem_bus.mem_req,
                     mem_bus.mem_addr, inst_valid, inst, inst_pc);
        end
        rst = 1'b0;
        step();
        checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL mid_restart: got req %b addr %h expected 1 %h", mem_bus.mem_req, mem_bus.mem_addr, RESET_PC);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rand_gnt = 1'b1;
        for (int i = 0; i < 400; i++) begin
            inst_ready  = ($urandom_range(0, 3) != 0);
            lat         = $urandom_range(1, 3);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            step();
        end
        redirect   = 1'b0;
        rand_gnt   = 1'b0;
        gnt_en     = 1'b1;
        inst_ready = 1'b1;
        repeat (30) step();
        checks++;
        if (cons_log.size() < 20) begin
            errors++;
            $display("FAIL random_progress: got %0d instructions expected at least 20", cons_log.size());
        end
    endtask

    initial begin
        clk                = 1'b0;
        rst                = 1'b1;
        redirect           = 1'b0;
        redirect_pc        = '0;
        inst_ready         = 1'b0;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_full();
        test_wrap();
        test_reset_mid();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
